// File: rtl/bpt_index_gen.sv
// bpt_index_gen
// Turns one registered BPT row lookup into the sub-word's physical entry
// address in the next-level SRAM: out_addr = li - (ones in the bitmap strictly
// after bpi). The bitmap is counted serially, CHUNK bits per cycle.
// Bitmap index 0 is the leftmost (MSB) position.
module bpt_index_gen #(
    parameter int W     = 16,
    parameter int B     = 8,
    parameter int CHUNK = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:2**B-1] data,
    input  logic [W:0]      li,
    input  logic [B-1:0]    bpi,
    input  logic            in_sw_pre,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W:0]      out_addr,
    output logic            out_hit,
    output logic            out_err,
    output logic            busy
);

    localparam int NBITS = 2**B;
    localparam int NCH   = NBITS / CHUNK;
    localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [0:NBITS-1]    data_r;
    logic [W:0]          li_r;
    logic [B-1:0]        bpi_r;
    logic [B:0]          cnt;
    logic [KW-1:0]       k;

    logic                accept;
    logic                last_chunk;
    logic [B-1:0]        chunk_base;
    logic [B-1:0]        pos;
    logic [B:0]          chunk_pop;
    logic [B:0]          cnt_sum;
    logic [W:0]          cnt_ext;
    logic                final_hit;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (k == KW'(NCH - 1));
    assign chunk_base = B'(k) * B'(CHUNK);
    assign cnt_sum    = cnt + chunk_pop;
    assign cnt_ext    = (W+1)'(cnt_sum);
    assign final_hit  = (cnt_ext <= li_r);

    // Population count of the current chunk, keeping only positions after bpi_r
    always_comb begin
        chunk_pop = '0;
        pos       = '0;
        for (int j = 0; j < CHUNK; j++) begin
            pos = chunk_base + B'(j);
            if (pos > bpi_r) begin
                chunk_pop = chunk_pop + {{B{1'b0}}, data_r[pos]};
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: absent sub-words skip counting, counting ends after the last chunk
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = in_sw_pre ? COUNT : DONE;
                end
            end
            COUNT: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the request, accumulate the count, and fix the result on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r   <= '0;
            li_r     <= '0;
            bpi_r    <= '0;
            cnt      <= '0;
            k        <= '0;
            out_addr <= '0;
            out_hit  <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_r   <= data;
                        li_r     <= li;
                        bpi_r    <= bpi;
                        cnt      <= '0;
                        k        <= '0;
                        out_addr <= '0;
                        out_hit  <= 1'b0;
                        out_err  <= 1'b0;
                    end
                end
                COUNT: begin
                    cnt <= cnt_sum;
                    k   <= k + KW'(1);
                    if (last_chunk) begin
                        out_hit  <= final_hit;
                        out_err  <= !final_hit;
                        out_addr <= final_hit ? (li_r - cnt_ext) : '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_addr <= '0;
                        out_hit  <= 1'b0;
                        out_err  <= 1'b0;
                    end
                end
                default: begin
                    cnt <= '0;
                    k   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpt_index_gen.sv
// tb_bpt_index_gen
// Drives directed and random lookups into bpt_index_gen and compares the
// result, latency and handshake behaviour against a counting model.
module tb_bpt_index_gen;

    localparam int W     = 16;
    localparam int B     = 8;
    localparam int CHUNK = 32;
    localparam int NB    = 2**B;
    localparam int NCH   = NB / CHUNK;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [0:NB-1]   data;
    logic [W:0]      li;
    logic [B-1:0]    bpi;
    logic            in_sw_pre;
    logic            out_valid;
    logic            out_ready;
    logic [W:0]      out_addr;
    logic            out_hit;
    logic            out_err;
    logic            busy;

    int n_compared;
    int n_mismatched;

    bpt_index_gen #(.W(W), .B(B), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .li        (li),
        .bpi       (bpi),
        .in_sw_pre (in_sw_pre),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_hit   (out_hit),
        .out_err   (out_err),
        .busy      (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic randomBitmap(output logic [0:NB-1] bm);
        for (int i = 0; i < NB / 32; i++) begin
            bm[i*32 +: 32] = $urandom;
        end
    endtask

    // Full lookup: present request, wait for the result, check it, hold, then release
    task automatic applyStimulus(input logic [0:NB-1] bm, input logic [W:0] l, input logic [B-1:0] b,
                                 input logic pre, input int hold, input string name);
        int          c;
        int          lat;
        logic        exp_hit;
        logic        exp_err;
        logic [W:0]  exp_addr;
        int          exp_lat;
        logic [0:NB-1] junk;

        c = 0;
        for (int p = 0; p < NB; p++) begin
            if (p > int'(b) && bm[p]) c++;
        end
        if (pre) begin
            exp_hit  = (c <= int'(l));
            exp_err  = !exp_hit;
            exp_addr = exp_hit ? (W+1)'(int'(l) - c) : '0;
            exp_lat  = NCH + 1;
        end else begin
            exp_hit  = 1'b0;
            exp_err  = 1'b0;
            exp_addr = '0;
            exp_lat  = 1;
        end

        @(negedge clk);
        checkOutput({name, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        data      = bm;
        li        = l;
        bpi       = b;
        in_sw_pre = pre;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        randomBitmap(junk);
        data      = junk;
        li        = (W+1)'($urandom);
        bpi       = B'($urandom);
        in_sw_pre = 1'b0;

        lat = 1;
        while (!out_valid && lat < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        checkOutput({name, ".latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, ".addr"}, 32'(out_addr), 32'(exp_addr));
        checkOutput({name, ".hit"}, 32'(out_hit), 32'(exp_hit));
        checkOutput({name, ".err"}, 32'(out_err), 32'(exp_err));
        checkOutput({name, ".busy"}, 32'(busy), 32'd1);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checkOutput({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({name, ".hold_addr"}, 32'(out_addr), 32'(exp_addr));
            checkOutput({name, ".hold_hit"}, 32'(out_hit), 32'(exp_hit));
            checkOutput({name, ".hold_err"}, 32'(out_err), 32'(exp_err));
            checkOutput({name, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end

        @(negedge clk);
        out_ready = 1'b1;
        checkOutput({name, ".in_ready_hs"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, ".valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({name, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [0:NB-1] bm;
        logic [B-1:0]  rb;
        int            ghost;

        n_compared   = 0;
        n_mismatched = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        data      = '0;
        li        = '0;
        bpi       = '0;
        in_sw_pre = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.out_addr", 32'(out_addr), 32'd0);
        checkOutput("reset.out_hit", 32'(out_hit), 32'd0);
        checkOutput("reset.out_err", 32'(out_err), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        applyStimulus('1, 17'd300, 8'd0, 1'b1, 0, "ones_bpi0");
        applyStimulus('1, 17'd17, 8'd255, 1'b1, 1, "ones_bpi255");
        bm = '0;
        bm[10] = 1'b1; bm[40] = 1'b1; bm[200] = 1'b1;
        applyStimulus(bm, 17'd50, 8'd10, 1'b1, 2, "sparse");
        bm = '0;
        applyStimulus(bm, 17'd99, 8'd33, 1'b0, 5, "absent");
        applyStimulus('1, 17'd100, 8'd0, 1'b1, 1, "corrupt");
        bm = '0;
        bm[0] = 1'b1; bm[255] = 1'b1;
        applyStimulus(bm, 17'd1, 8'd0, 1'b1, 0, "edges");

        // Reset in the middle of counting discards the lookup
        @(negedge clk);
        in_valid = 1'b1; data = '1; li = 17'd300; bpi = 8'd0; in_sw_pre = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ghost = 0;
        for (int i = 0; i < NCH + 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ghost++;
        end
        checkOutput("midrst.no_output", 32'(ghost), 32'd0);
        bm = '0;
        bm[20] = 1'b1;
        applyStimulus(bm, 17'd7, 8'd5, 1'b1, 0, "after_rst");

        // Random lookups, with li spread to hit both the normal and corrupt outcomes
        for (int t = 0; t < 30; t++) begin
            randomBitmap(bm);
            rb = B'($urandom);
            if (t % 5 == 0) begin
                bm[rb] = 1'b0;
                applyStimulus(bm, (W+1)'($urandom_range(0, 400)), rb, 1'b0, $urandom_range(0, 3), "rand_absent");
            end else begin
                bm[rb] = 1'b1;
                applyStimulus(bm, (W+1)'($urandom_range(0, 300)), rb, 1'b1, $urandom_range(0, 3), "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
